// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and memory-side handshakes
// for mem_port_arbiter.
//   fetch : if_req, if_addr  -> arbiter;  if_rdata, if_done  <- arbiter
//   data  : d_read, d_write, d_addr, d_wdata -> arbiter;  d_rdata, d_done <- arbiter
//   memory: mem_req, mem_we, mem_addr, mem_wdata <- arbiter;  mem_rdata, mem_ack -> arbiter
//   status: stall, owner <- arbiter
// Modports: slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              stall;
  logic [1:0]        owner;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
           stall, owner
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
           stall, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch and the
// load/store datapath. Accesses are serialised through IDLE -> ISSUE -> DONE;
// data wins over fetch, read data is returned in a per-requester register,
// and stall is held while any request is outstanding.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - mem_port_arbiter_if.slave (fetch, data, memory, stall, owner)
// Parameters: ADDR_W, DATA_W, STARVE_LIMIT (fairness build only).
// Build option: define ARB_FAIRNESS_EN to let a starved fetch win after
// STARVE_LIMIT consecutive data grants; otherwise strict data priority.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_FETCH = 2'b01, OWN_DATA = 2'b10} owner_t;

  state_t state, state_nxt;
  owner_t own;

  logic              mem_req_q, mem_we_q, if_done_q, d_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

  logic d_pend, if_pend, fetch_override, grant_d, grant_f;

  assign d_pend  = bus.d_read | bus.d_write;
  assign if_pend = bus.if_req;

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign fetch_override = if_pend & d_pend & (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset)                  starve_cnt <= '0;
    else if (grant_f)           starve_cnt <= '0;
    else if (grant_d & if_pend) starve_cnt <= starve_cnt + CNT_W'(1);
  end
`else
  // Strict data priority; STARVE_LIMIT only matters in the fairness build.
  assign fetch_override = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend && !fetch_override) begin
          grant_d   = 1'b1;
          state_nxt = ISSUE;
        end else if (if_pend) begin
          grant_f   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   if (bus.mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access fields are latched at grant so requester changes during ISSUE
  // cannot disturb the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      own         <= OWN_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            own         <= OWN_DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_write;   // read+write together is a write
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end else if (grant_f) begin
            own        <= OWN_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
          end
        end
        ISSUE: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (own == OWN_FETCH) begin
              if_rdata_q <= bus.mem_rdata;
              if_done_q  <= 1'b1;
            end else begin
              if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
              d_done_q <= 1'b1;
            end
          end
        end
        DONE:    own <= OWN_NONE;
        default: own <= OWN_NONE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.owner     = own;
  assign bus.stall     = (if_pend & ~if_done_q) | (d_pend & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Memory model: acks in the mem_lat-th cycle of mem_req (0 = never).
  int          mem_lat = 1;
  int          lat_cnt = 0;
  logic        auto_ack = 1'b0;
  logic        kick_ack = 1'b0;
  logic [31:0] rd_word = '0;

  assign bus.mem_ack   = auto_ack | kick_ack;
  assign bus.mem_rdata = rd_word;

  initial begin
    forever begin
      @(negedge clk);
      if (reset || !bus.mem_req || auto_ack) begin
        auto_ack = 1'b0;
        lat_cnt  = 0;
      end else begin
        lat_cnt++;
        auto_ack = (mem_lat != 0) && (lat_cnt == mem_lat);
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic [1:0]  own;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } done_t;

  grant_t gq[$];
  done_t  dq[$];
  int     gcyc[$];
  int     cyc = 0;
  logic   prev_req = 1'b0;
  grant_t g;
  done_t  d;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_req && !prev_req) begin
        gcyc.push_back(cyc);
        if (gq.size() == 0) note_fail("grant_unexpected");
        else begin
          g = gq.pop_front();
          chk("grant_owner", {30'd0, bus.owner}, {30'd0, g.own});
          chk("grant_we", {31'd0, bus.mem_we}, {31'd0, g.we});
          chk("grant_addr", bus.mem_addr, g.addr);
          if (g.we) chk("grant_wdata", bus.mem_wdata, g.wdata);
        end
      end
      prev_req = bus.mem_req;
      if (bus.if_done || bus.d_done) begin
        if (dq.size() == 0) note_fail("done_unexpected");
        else begin
          d = dq.pop_front();
          chk("done_kind", {30'd0, bus.if_done, bus.d_done}, d.is_data ? 32'd1 : 32'd2);
          if (d.is_data) chk("done_d_rdata", bus.d_rdata, d.rdata);
          else           chk("done_if_rdata", bus.if_rdata, d.rdata);
        end
      end
    end
  end

  // Requester behaviour: drop a request in the cycle its done pulse shows.
  task automatic serve(input int budget);
    int n = 0;
    while ((bus.if_req || bus.d_read || bus.d_write) && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.if_done) bus.if_req = 1'b0;
      if (bus.d_done) begin
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
      end
    end
    if (n >= budget) begin
      note_fail("serve_timeout");
      bus.if_req  = 1'b0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  string order;
  int    ndone;
  int    nfetch;
  int    guard;

  initial begin
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_dones", {30'd0, bus.if_done, bus.d_done}, 32'd0);
    chk("rst_owner", {30'd0, bus.owner}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Lone fetch, minimum latency
    mem_lat = 1;
    rd_word = 32'h20080005;
    gq.push_back('{own: 2'b01, we: 1'b0, addr: 32'h00400000, wdata: 32'h0});
    dq.push_back('{is_data: 1'b0, rdata: 32'h20080005});
    bus.if_addr = 32'h00400000;
    bus.if_req  = 1'b1;
    @(negedge clk);
    chk("t1_c1_mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("t1_c1_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("t1_c1_stall", {31'd0, bus.stall}, 32'd1);
    chk("t1_c1_if_done", {31'd0, bus.if_done}, 32'd0);
    @(negedge clk);
    chk("t1_c2_if_done", {31'd0, bus.if_done}, 32'd1);
    chk("t1_c2_if_rdata", bus.if_rdata, 32'h20080005);
    chk("t1_c2_stall", {31'd0, bus.stall}, 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("t1_c3_if_done", {31'd0, bus.if_done}, 32'd0);
    chk("t1_c3_owner", {30'd0, bus.owner}, 32'd0);
    chk("t1_c3_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);

    // Simultaneous fetch and store: data first, one IDLE gap, then fetch
    rd_word = 32'h12345678;
    gcyc.delete();
    gq.push_back('{own: 2'b10, we: 1'b1, addr: 32'h10010000, wdata: 32'hDEADBEEF});
    gq.push_back('{own: 2'b01, we: 1'b0, addr: 32'h00400004, wdata: 32'h0});
    dq.push_back('{is_data: 1'b1, rdata: 32'h0});
    dq.push_back('{is_data: 1'b0, rdata: 32'h12345678});
    bus.if_addr = 32'h00400004;
    bus.d_addr  = 32'h10010000;
    bus.d_wdata = 32'hDEADBEEF;
    bus.if_req  = 1'b1;
    bus.d_write = 1'b1;
    serve(40);
    chk("t2_grants", gcyc.size(), 32'd2);
    if (gcyc.size() >= 2) chk("t2_gap", gcyc[1] - gcyc[0], 32'd3);
    chk("t2_d_rdata", bus.d_rdata, 32'd0);

    // Load with 5-cycle memory latency; requester changes fields mid-access
    mem_lat = 5;
    rd_word = 32'hCAFEF00D;
    gq.push_back('{own: 2'b10, we: 1'b0, addr: 32'h10010004, wdata: 32'h0});
    dq.push_back('{is_data: 1'b1, rdata: 32'hCAFEF00D});
    bus.d_addr = 32'h10010004;
    bus.d_read = 1'b1;
    for (int unsigned i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t3_mem_req", {31'd0, bus.mem_req}, 32'd1);
      chk("t3_mem_addr", bus.mem_addr, 32'h10010004);
      chk("t3_stall", {31'd0, bus.stall}, 32'd1);
      chk("t3_d_done_early", {31'd0, bus.d_done}, 32'd0);
      if (i == 2) bus.d_addr = 32'hFFFF0000;
    end
    @(negedge clk);
    chk("t3_d_done", {31'd0, bus.d_done}, 32'd1);
    chk("t3_d_rdata", bus.d_rdata, 32'hCAFEF00D);
    chk("t3_mem_req_off", {31'd0, bus.mem_req}, 32'd0);
    bus.d_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_lat = 1;

    // Read and write together: issued as a write, d_rdata kept
    rd_word = 32'h55555555;
    gq.push_back('{own: 2'b10, we: 1'b1, addr: 32'h10010008, wdata: 32'h0BADF00D});
    dq.push_back('{is_data: 1'b1, rdata: 32'hCAFEF00D});
    bus.d_addr  = 32'h10010008;
    bus.d_wdata = 32'h0BADF00D;
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    serve(40);
    chk("t6_d_rdata", bus.d_rdata, 32'hCAFEF00D);

    // Continuous loads with a waiting fetch
`ifdef ARB_FAIRNESS_EN
    order = "DDDDFD";
`else
    order = "DDDDDD";
`endif
    rd_word = 32'h0F0F0F0F;
    gcyc.delete();
    for (int i = 0; i < 6; i++) begin
      if (order[i] == "D") begin
        gq.push_back('{own: 2'b10, we: 1'b0, addr: 32'h10010010, wdata: 32'h0});
        dq.push_back('{is_data: 1'b1, rdata: 32'h0F0F0F0F});
      end else begin
        gq.push_back('{own: 2'b01, we: 1'b0, addr: 32'h00400008, wdata: 32'h0});
        dq.push_back('{is_data: 1'b0, rdata: 32'h0F0F0F0F});
      end
    end
    bus.d_addr  = 32'h10010010;
    bus.if_addr = 32'h00400008;
    bus.d_read  = 1'b1;
    bus.if_req  = 1'b1;
    ndone  = 0;
    nfetch = 0;
    guard  = 0;
    while (ndone < 6 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (bus.if_done) begin
        bus.if_req = 1'b0;
        nfetch++;
      end
      if (bus.if_done || bus.d_done) ndone++;
    end
    if (guard >= 60) note_fail("t5_timeout");
    bus.d_read = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_grants", gcyc.size(), 32'd6);
`ifdef ARB_FAIRNESS_EN
    chk("t5_fetch_grants", nfetch, 32'd1);
`else
    chk("t5_fetch_grants", nfetch, 32'd0);
`endif

    // Reset during ISSUE, then a late ack
    mem_lat = 0;
    gq.push_back('{own: 2'b01, we: 1'b0, addr: 32'h00400010, wdata: 32'h0});
    bus.if_addr = 32'h00400010;
    bus.if_req  = 1'b1;
    @(negedge clk);
    chk("t4_c1_mem_req", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    chk("t4_c2_owner", {30'd0, bus.owner}, 32'd1);
    reset      = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("t4_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("t4_rst_owner", {30'd0, bus.owner}, 32'd0);
    chk("t4_rst_if_rdata", bus.if_rdata, 32'd0);
    chk("t4_rst_d_rdata", bus.d_rdata, 32'd0);
    chk("t4_rst_if_done", {31'd0, bus.if_done}, 32'd0);
    reset    = 1'b0;
    kick_ack = 1'b1;
    @(negedge clk);
    kick_ack = 1'b0;
    chk("t4_late_dones", {30'd0, bus.if_done, bus.d_done}, 32'd0);
    chk("t4_late_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    chk("t4_after_dones", {30'd0, bus.if_done, bus.d_done}, 32'd0);
    chk("t4_after_stall", {31'd0, bus.stall}, 32'd0);
    chk("t4_after_owner", {30'd0, bus.owner}, 32'd0);

    chk("gq_empty", gq.size(), 32'd0);
    chk("dq_empty", dq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
